// File: rtl/cpu_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ram_responder
//  Description : Single-port word RAM serving a CPU, fronted by a
//                power-on sequencer. After reset the whole array is swept
//                to zero (CLEAR). An optional preload phase (LOAD) then
//                accepts words from a loader. Finally the CPU gets
//                registered read/write access (RUN).
//                Writes that hit OUT_ADDR are also mirrored to out_port.
//  Ports       : clk          - clock, rising-edge active
//                rst          - synchronous, active-low reset
//                addr_toRAM   - CPU word address
//                wrEn         - CPU write strobe (honoured only in RUN)
//                data_toRAM   - CPU write data
//                data_fromRAM - registered read data (write-first), 0 outside RUN
//                ld_mode      - request LOAD after CLEAR
//                ld_valid     - loader word valid
//                ld_addr      - loader word address
//                ld_data      - loader word data
//                ld_done      - loader finished (pulse)
//                ld_ready     - loader may present words (LOAD only)
//                cpu_hold     - keep CPU in reset (CLEAR/LOAD)
//                out_port     - last value written to OUT_ADDR
//                wr_count     - saturating count of CPU writes in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ram_responder #(
    parameter int ADDR_W   = 13,
    parameter int OUT_ADDR = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_toRAM,
    input  logic              wrEn,
    input  logic [15:0]       data_toRAM,
    output logic [15:0]       data_fromRAM,
    input  logic              ld_mode,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic [15:0]       out_port,
    output logic [15:0]       wr_count
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_ptr = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_out_addr = ADDR_W'(OUT_ADDR);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [15:0]       r_mem [c_depth];

    // Single write port shared by the clear sweep, the loader and the CPU;
    // the FSM decides who owns it each cycle.
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [15:0]       w_wdata;
    logic              w_out_we;
    logic              w_cpu_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_clr_ptr;
        w_wdata     = 16'h0000;
        w_out_we    = 1'b0;
        w_cpu_wr    = 1'b0;
        ld_ready    = 1'b0;
        cpu_hold    = 1'b1;
        case (r_state)
            S_CLEAR: begin
                // Clear writes never touch out_port.
                w_we = 1'b1;
                if (r_clr_ptr == c_last_ptr) begin
                    w_state_nxt = ld_mode ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                // A word presented together with ld_done is still taken.
                if (ld_valid) begin
                    w_we     = 1'b1;
                    w_waddr  = ld_addr;
                    w_wdata  = ld_data;
                    w_out_we = (ld_addr == c_out_addr);
                end
                if (ld_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                cpu_hold = 1'b0;
                if (wrEn) begin
                    w_cpu_wr = 1'b1;
                    w_we     = 1'b1;
                    w_waddr  = addr_toRAM;
                    w_wdata  = data_toRAM;
                    w_out_we = (addr_toRAM == c_out_addr);
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_CLEAR;
            r_clr_ptr    <= '0;
            data_fromRAM <= 16'h0000;
            out_port     <= 16'h0000;
            wr_count     <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            // Pointer wraps back to zero as the sweep finishes.
            if (r_state == S_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if (r_state == S_RUN) begin
                data_fromRAM <= wrEn ? data_toRAM : r_mem[addr_toRAM];
            end else begin
                data_fromRAM <= 16'h0000;
            end
            if (w_out_we) begin
                out_port <= w_wdata;
            end
            if (w_cpu_wr && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Array has no reset of its own; the CLEAR sweep zeroes it. Reset
    // suppresses any write pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_ram_responder.md
CPU_RAM_RESPONDER -- requirements
Module: cpu_ram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the word-address width; depth is 2^ADDR_W words.
REQ-002 The block SHALL have parameter OUT_ADDR, default 2^ADDR_W-1, meaning the word address mirrored to out_port on write.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-low (rst=0 sampled at a rising edge resets the block).
REQ-005 The block SHALL have port addr_toRAM  input  ADDR_W  CPU word address, valid every cycle.
REQ-006 The block SHALL have port wrEn  input  1  CPU write strobe.
REQ-007 The block SHALL have port data_toRAM  input  16  CPU write data.
REQ-008 The block SHALL have port data_fromRAM  output  16  registered read data to the CPU.
REQ-009 The block SHALL have port ld_mode  input  1  request preload phase after clear.
REQ-010 The block SHALL have port ld_valid  input  1  loader word valid.
REQ-011 The block SHALL have port ld_addr  input  ADDR_W  loader word address.
REQ-012 The block SHALL have port ld_data  input  16  loader word data.
REQ-013 The block SHALL have port ld_done  input  1  loader finished; single-cycle pulse.
REQ-014 The block SHALL have port ld_ready  output  1  loader word accepted when ld_valid&ld_ready.
REQ-015 The block SHALL have port cpu_hold  output  1  high whenever the CPU must be held in reset (state not RUN).
REQ-016 The block SHALL have port out_port  output  16  last value written to OUT_ADDR by CPU or loader.
REQ-017 The block SHALL have port wr_count  output  16  count of CPU writes accepted in RUN, saturating at 0xFFFF.

Function
REQ-018 FSM states SHALL be CLEAR, LOAD, RUN; encoding is implementation choice.
REQ-019 CLEAR: one word per cycle, clear pointer 0 -> 2^ADDR_W-1, each written 0x0000; after writing the last word, next state LOAD if ld_mode=1 at that edge, else RUN.
REQ-020 LOAD: ld_ready=1; on ld_valid&ld_ready, mem[ld_addr] <= ld_data at that edge; ld_done=1 moves to RUN next cycle; a word with ld_valid in the same cycle as ld_done SHALL still be written.
REQ-021 RUN: terminal state until reset; ld_mode, ld_valid, ld_done ignored; ld_ready=0.
REQ-022 cpu_hold SHALL be 1 in CLEAR and LOAD, 0 in RUN, registered with the state.
REQ-023 RUN read: data_fromRAM SHALL update at each rising edge to mem[addr_toRAM] sampled at that edge (one-cycle latency: address in cycle N, data visible in cycle N+1).
REQ-024 RUN write: wrEn=1 at an edge SHALL store data_toRAM to mem[addr_toRAM]; read-during-write is write-first (data_fromRAM next cycle equals data_toRAM).
REQ-025 Every accepted RUN write SHALL increment wr_count by 1, holding at 0xFFFF once reached.
REQ-026 Outside RUN, CPU wrEn SHALL be ignored (no memory change, no count), and data_fromRAM SHALL be 0x0000.
REQ-027 Any accepted write (CPU in RUN or loader in LOAD) to OUT_ADDR SHALL also load out_port with the same data at the same edge; CLEAR writes SHALL NOT change out_port.
REQ-028 Addresses wrap naturally at ADDR_W bits; no out-of-range condition exists.

Reset
REQ-029 rst=0 at an edge SHALL set state CLEAR, clear pointer 0, data_fromRAM 0x0000, out_port 0x0000, wr_count 0, ld_ready 0, cpu_hold 1, overriding all other inputs.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation that cycle (pending write discarded) and restart the full CLEAR sweep on release.
REQ-031 Memory contents SHALL be 0x0000 for every address after CLEAR completes, regardless of contents before reset.

Verification
REQ-032 ADDR_W=4, ld_mode=0, release reset -> cpu_hold=1 for exactly 16 cycles then 0; reads of addresses 0..15 return 0x0000.
REQ-033 ld_mode=1, load {0:0xA003, 1:0x0004, 15:0x1234} with ld_valid held and ld_done on last word -> RUN; CPU reads return those values; out_port=0x1234 (OUT_ADDR=15).
REQ-034 RUN, wrEn=1 addr 5 data 0xBEEF while reading addr 5 -> data_fromRAM=0xBEEF next cycle; wr_count=1.
REQ-035 RUN, 65537 CPU writes -> wr_count stops at 0xFFFF.
REQ-036 Reset pulse during LOAD after 3 words -> CLEAR reruns, those 3 addresses read 0x0000, out_port=0x0000.
REQ-037 wrEn=1 during CLEAR and LOAD -> no memory change, wr_count stays 0, data_fromRAM stays 0x0000.
